rr_arbiter: RTL
===============

# rr_arbiter

Round-robin arbiter that shares one datapath resource (e.g. the `Top` compute core) among `NUM_REQ` requesters. Each requester raises a level request and keeps ownership while the request stays high. Fairness comes from a rotating priority pointer. An optional hold-limit timer preempts an owner that holds the resource too long while others wait. It sits between the requester front-ends and the shared resource's input mux, driving the mux select and a one-hot grant.

## Interface
- `NUM_REQ`, 4: number of requesters; legal range 2..16.
- `MAX_HOLD`, 8: maximum consecutive owned cycles before preemption (timeout build only); legal range 1..255.
- `ID_BITS`, `$clog2(NUM_REQ)`: width of `gnt_id`; derived, never overridden.
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `req`, input, `NUM_REQ`: per-requester level request; bit i belongs to requester i.
- `gnt`, output, `NUM_REQ`: registered one-hot grant; all zero when idle.
- `gnt_id`, output, `ID_BITS`: registered binary index of the owner; valid only while `busy`=1.
- `busy`, output, 1: registered; 1 while any grant is active.
- `preempt`, output, 1: registered one-cycle pulse on the edge where a grant is revoked by timeout.

## Operation
- Two states: IDLE and OWNED.
- Reset values: state=IDLE, `gnt`=0, `gnt_id`=0, `busy`=0, `preempt`=0, `ptr`=0, `hold_cnt`=0.
- `ptr` is the highest-priority index. Search order is `ptr`, `ptr`+1, …, `NUM_REQ`-1, 0, …, `ptr`-1, modulo `NUM_REQ`.
- IDLE, `req`≠0: grant the first requester k with `req[k]` set, in search order. Set `hold_cnt`=1 and go to OWNED.
- IDLE, `req`=0: remain in IDLE.
- OWNED, owner's `req` still high and no preemption: keep the grant and increment `hold_cnt`, saturating at `MAX_HOLD`.
- OWNED, owner's `req` sampled low (release):
  - Set `ptr` = owner+1 (mod `NUM_REQ`).
  - Re-arbitrate in the same edge over `req` with the owner's bit masked. This gives a back-to-back handoff with no bubble.
  - If no other request is pending, go to IDLE with `gnt`=0.
- Requests from non-owners never disturb the current grant, except through preemption.
- `req` bits of non-owners may toggle freely. A request dropped before it is granted is simply lost; the arbiter keeps no pending memory.
- Exactly one `gnt` bit is set while `busy`=1. `gnt_id` always equals the index of that bit.

## Timing
- Grant latency: `req` rises in cycle t; `gnt` is visible in cycle t+1.
- Release handoff: the owner drops `req` in cycle t. In cycle t+1 either the new `gnt` is visible, or `gnt`=0 with `busy`=0.
- Preemption (timeout build):
  - Condition: `hold_cnt`=`MAX_HOLD` and at least one other `req` bit is set.
  - At that edge the grant moves to the next requester in search order starting from owner+1, `ptr` becomes owner+1, and `preempt` pulses for one cycle.
  - The preempted owner, if still requesting, re-competes normally.
- Owner alone at `MAX_HOLD`: no preemption; `hold_cnt` stays saturated.
- Owner release and the preemption condition in the same edge: release wins and `preempt` stays 0.
- `rst_n` asserted mid-grant: all outputs clear immediately (asynchronously). The first grant after deassertion uses `ptr`=0.

## Configuration
- `ARB_TIMEOUT_EN` defined: the `hold_cnt` comparator and preemption logic are compiled in, as described above.
- `ARB_TIMEOUT_EN` undefined:
  - Ownership lasts until the owner drops `req`.
  - `preempt` is tied to 0.
  - `hold_cnt` is removed and `MAX_HOLD` is ignored.

## Test plan
- Reset: hold `rst_n`=0 with `req`=4'b1111 → `gnt`=0, `busy`=0, `gnt_id`=0. Release reset → next cycle `gnt`=4'b0001, `gnt_id`=0.
- Rotation: `req`=4'b1111 held. Each owner drops `req` for one cycle after 2 owned cycles → grant order 0,1,2,3,0 with no idle cycle between owners.
- Single requester: `req`=4'b0100 for 20 cycles → `gnt`=4'b0100 throughout, `preempt`=0. Drop `req` → `gnt`=0 the next cycle.
- Timeout (`ARB_TIMEOUT_EN`, `MAX_HOLD`=8):
  - Stimulus: requester 1 holds `req`; requester 3 raises `req` in owned cycle 3.
  - Response: after 8 owned cycles `gnt` goes 4'b0010 → 4'b1000 and `preempt`=1 for exactly one cycle.
  - Without the macro: `gnt` stays 4'b0010 until requester 1 drops `req`.
- Release/timeout collision: at `hold_cnt`=8 the owner drops `req` while another request is pending → handoff occurs with `preempt`=0.
- Mid-grant reset: pulse `rst_n` low while `gnt`=4'b1000 → `gnt` clears within the same cycle. After reset, with `req`=4'b1010, the first grant is 4'b0010 (`ptr`=0).

Source files
------------

// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between the requester front-ends and rr_arbiter.
//   req     : per-requester level request (bit i = requester i)
//   gnt     : registered one-hot grant, zero when idle
//   gnt_id  : registered binary index of the owner, valid while busy
//   busy    : registered, high while a grant is active
//   preempt : registered one-cycle pulse when a grant is revoked by timeout
// The master modport is the requester side; the slave modport is the arbiter.
interface rr_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    localparam int unsigned ID_BITS = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_BITS-1:0] gnt_id;
    logic               busy;
    logic               preempt;

    modport master (
        output req,
        input  gnt,
        input  gnt_id,
        input  busy,
        input  preempt
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_id,
        output busy,
        output preempt
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for a shared datapath resource. A requester keeps ownership while its
// level request stays high; a rotating priority pointer gives fairness, and a release hands
// off to the next requester on the same edge with no bubble.
// Optional feature: define ARB_TIMEOUT_EN to compile in the hold-limit timer that preempts an
// owner after MAX_HOLD consecutive owned cycles while others wait. Without it, preempt is 0.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : rr_arbiter_if slave modport (req in; gnt, gnt_id, busy, preempt out)
module rr_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    rr_arbiter_if.slave  bus
);
    localparam int unsigned ID_BITS = $clog2(NUM_REQ);

    typedef enum logic [0:0] {StIdle, StOwned} state_e;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [ID_BITS-1:0] id_q, id_d;
    logic [ID_BITS-1:0] ptr_q, ptr_d;
    logic [NUM_REQ-1:0] others_req;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HoldMax = 8'(MAX_HOLD);
    logic [7:0] hold_q, hold_d;
    logic       preempt_q, preempt_d;
`else
    logic unused_max_hold;
    assign unused_max_hold = ^8'(MAX_HOLD);
`endif

    // Index after idx, wrapping at NUM_REQ (which need not be a power of two).
    function automatic logic [ID_BITS-1:0] inc_idx(input logic [ID_BITS-1:0] idx);
        return (idx == ID_BITS'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    endfunction

    // First set bit of r searching from start with wrap-around; caller guarantees r != 0.
    function automatic logic [ID_BITS-1:0] pick(input logic [NUM_REQ-1:0] r,
                                               input logic [ID_BITS-1:0] start);
        logic [ID_BITS-1:0] idx;
        logic [ID_BITS-1:0] sel;
        logic               found;
        idx   = start;
        sel   = start;
        found = 1'b0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (!found && r[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
            idx = inc_idx(idx);
        end
        return sel;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_BITS-1:0] idx);
        return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    // gnt_q is the owner mask while owned, so this is every pending request except the owner.
    assign others_req = bus.req & ~gnt_q;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
        hold_d    = hold_q;
        preempt_d = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (|bus.req) begin
                    id_d    = pick(bus.req, ptr_q);
                    gnt_d   = onehot(id_d);
                    state_d = StOwned;
`ifdef ARB_TIMEOUT_EN
                    hold_d  = 8'd1;
`endif
                end
            end
            StOwned: begin
                if (!bus.req[id_q]) begin
                    // Release takes precedence over a simultaneous timeout.
                    ptr_d = inc_idx(id_q);
                    if (|others_req) begin
                        id_d   = pick(others_req, ptr_d);
                        gnt_d  = onehot(id_d);
`ifdef ARB_TIMEOUT_EN
                        hold_d = 8'd1;
`endif
                    end else begin
                        state_d = StIdle;
                        gnt_d   = '0;
                        id_d    = '0;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_q == HoldMax && |others_req) begin
                    ptr_d     = inc_idx(id_q);
                    id_d      = pick(others_req, ptr_d);
                    gnt_d     = onehot(id_d);
                    hold_d    = 8'd1;
                    preempt_d = 1'b1;
                end else if (hold_q != HoldMax) begin
                    hold_d = hold_q + 8'd1;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= '0;
            preempt_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            preempt_q <= preempt_d;
        end
    end
    assign bus.preempt = preempt_q;
`else
    assign bus.preempt = 1'b0;
`endif

    assign bus.gnt    = gnt_q;
    assign bus.gnt_id = id_q;
    assign bus.busy   = (state_q == StOwned);
endmodule
